// File: rtl/arb_pkg.sv
// Shared definitions for the three-port round-robin arbiter: state codes,
// one-hot requester constants and one-hot helper functions.
package arb_pkg;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_BUSY = 2'b01;
  localparam logic [1:0] S_GAP  = 2'b10;

  localparam logic [2:0] OH_0 = 3'b001;
  localparam logic [2:0] OH_1 = 3'b010;
  localparam logic [2:0] OH_2 = 3'b100;

  function automatic logic [2:0] rotl1(input logic [2:0] v);
    return {v[1:0], v[2]};
  endfunction

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == OH_0) || (v == OH_1) || (v == OH_2);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request bit scanning from
// the one-hot priority pointer in ring order, or 000 when nothing qualifies.
module rr_pick
  import arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [2:0] prio,
  output logic [2:0] winner
);

  logic [2:0] cand;

  // A corrupt pointer yields no winner; the top repairs the pointer first.
  always_comb begin
    winner = 3'b000;
    cand   = prio;
    if (is_onehot3(prio)) begin
      for (int i = 0; i < 3; i++) begin
        if ((winner == 3'b000) && ((req & cand) != 3'b000)) begin
          winner = cand;
        end
        cand = rotl1(cand);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter3.sv
// Three-port round-robin arbiter with hold limit and a one-cycle gap after
// every release; grant drives the shared resource mux select directly.
module rr_arbiter3
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] grant,
  output logic       busy,
  output logic [2:0] prio,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       owner;
  logic [2:0]       pick;
  logic             owner_req;

  rr_pick u_pick (
    .req    (req),
    .prio   (prio),
    .winner (pick)
  );

  assign owner_req = (req & owner) != 3'b000;

  // owner remembers the last grant through GAP so the pointer can rotate past it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      grant   <= 3'b000;
      busy    <= 1'b0;
      prio    <= OH_0;
      timeout <= 1'b0;
      cnt     <= '0;
      owner   <= OH_0;
    end else begin
      timeout <= 1'b0;
      if (!is_onehot3(prio)) begin
        prio <= OH_0;
      end
      case (state)
        S_IDLE: begin
          if (pick != 3'b000) begin
            grant <= pick;
            busy  <= 1'b1;
            owner <= pick;
            cnt   <= '0;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          cnt <= cnt + 1'b1;
          if (done || !owner_req || (cnt == LIMIT)) begin
            grant   <= 3'b000;
            busy    <= 1'b0;
            state   <= S_GAP;
            timeout <= !done && owner_req;
          end
        end
        S_GAP: begin
          prio  <= rotl1(owner);
          state <= S_IDLE;
        end
        default: begin
          grant <= 3'b000;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter3.sv
// Self-checking bench for rr_arbiter3: directed scenarios plus random traffic,
// all compared every cycle against an index-based behavioural model.
module tb_rr_arbiter3;

  localparam int MAX_HOLD = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] req = 3'b000;
  logic       done = 1'b0;
  logic [2:0] grant;
  logic       busy;
  logic [2:0] prio;
  logic       timeout;

  int checks = 0;
  int passed = 0;

  // Model: phase 0=idle 1=owning 2=dead cycle; indices are requester numbers.
  int  m_phase = 0;
  int  m_own   = 0;
  int  m_pidx  = 0;
  int  m_held  = 0;
  bit  m_to    = 1'b0;

  rr_arbiter3 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .busy    (busy),
    .prio    (prio),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_out();
    logic [2:0] g;
    logic [2:0] p;
    g = (m_phase == 1) ? 3'(1 << m_own) : 3'b000;
    p = 3'(1 << m_pidx);
    return {g, (m_phase == 1), p, m_to};
  endfunction

  task automatic model_step(input logic [2:0] r, input logic d, input logic rs);
    if (!rs) begin
      m_phase = 0; m_pidx = 0; m_held = 0; m_to = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          m_to = 1'b0;
          if (r != 3'b000) begin
            for (int k = 2; k >= 0; k--) begin
              if (r[(m_pidx + k) % 3]) m_own = (m_pidx + k) % 3;
            end
            m_held  = 1;
            m_phase = 1;
          end
        end
        1: begin
          if (d) begin
            m_phase = 2; m_to = 1'b0;
          end else if (!r[m_own]) begin
            m_phase = 2; m_to = 1'b0;
          end else if (m_held == MAX_HOLD) begin
            m_phase = 2; m_to = 1'b1;
          end else begin
            m_held = m_held + 1;
          end
        end
        default: begin
          m_pidx  = (m_own + 1) % 3;
          m_phase = 0;
          m_to    = 1'b0;
        end
      endcase
    end
  endtask

  task automatic tick(input logic [2:0] r, input logic d, input logic rs);
    @(negedge clk);
    req = r; done = d; rst = rs;
    @(posedge clk);
    model_step(r, d, rs);
    #1;
  endtask

  task automatic test_reset();
    tick(3'b000, 1'b0, 1'b0);
    tick(3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(3'b000, 1'b0, 1'b1);
      checks++;
      if ({grant, busy, prio, timeout} !== {3'b000, 1'b0, 3'b001, 1'b0})
        $display("[TB] FAIL reset_idle cycle %0d: got g=%b b=%b p=%b t=%b, need g=000 b=0 p=001 t=0",
                 i, grant, busy, prio, timeout);
      else passed++;
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] seen[$];
    logic [2:0] exp_seq[4];
    logic [2:0] prev_g;
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    prev_g = 3'b000;
    for (int i = 0; i < 22; i++) begin
      tick(3'b111, (m_phase == 1 && m_held == 3), 1'b1);
      checks++;
      if ({grant, busy, prio, timeout} !== model_out())
        $display("[TB] FAIL round_robin cycle %0d: got %b, need %b", i, {grant, busy, prio, timeout}, model_out());
      else passed++;
      if (grant != 3'b000 && prev_g == 3'b000) seen.push_back(grant);
      prev_g = grant;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= seen.size())
        $display("[TB] FAIL rr_order grant %0d: got none, need %b", k, exp_seq[k]);
      else if (seen[k] !== exp_seq[k])
        $display("[TB] FAIL rr_order grant %0d: got %b, need %b", k, seen[k], exp_seq[k]);
      else passed++;
    end
    tick(3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int run = 0;
    int first_run = -1;
    int pulses = 0;
    int regrant_gap = -1;
    int since_to = -1;
    for (int i = 0; i < 40; i++) begin
      tick(3'b010, 1'b0, 1'b1);
      checks++;
      if ({grant, busy, prio, timeout} !== model_out())
        $display("[TB] FAIL timeout_trace cycle %0d: got %b, need %b", i, {grant, busy, prio, timeout}, model_out());
      else passed++;
      if (grant == 3'b010) run++;
      else if (run > 0 && first_run < 0) first_run = run;
      if (timeout) begin pulses++; if (since_to < 0) since_to = 0; end
      else if (since_to >= 0 && regrant_gap < 0) begin
        since_to++;
        if (grant == 3'b010) regrant_gap = since_to;
      end
    end
    checks++;
    if (first_run !== MAX_HOLD) $display("[TB] FAIL hold_length: got %0d, need %0d", first_run, MAX_HOLD);
    else passed++;
    checks++;
    if (pulses !== 2) $display("[TB] FAIL timeout_pulses: got %0d, need 2", pulses);
    else passed++;
    checks++;
    if (regrant_gap !== 2) $display("[TB] FAIL regrant_after_revoke: got %0d, need 2", regrant_gap);
    else passed++;
    tick(3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_done_at_limit();
    tick(3'b001, 1'b0, 1'b1);
    for (int i = 0; i < MAX_HOLD + 3; i++) begin
      tick(3'b001, (m_phase == 1 && m_held == MAX_HOLD), 1'b1);
      checks++;
      if ({grant, busy, prio, timeout} !== model_out())
        $display("[TB] FAIL done_at_limit cycle %0d: got %b, need %b", i, {grant, busy, prio, timeout}, model_out());
      else passed++;
      checks++;
      if (timeout !== 1'b0) $display("[TB] FAIL done_at_limit_no_timeout cycle %0d: got %b, need 0", i, timeout);
      else passed++;
    end
    tick(3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_busy();
    tick(3'b100, 1'b0, 1'b1);
    tick(3'b100, 1'b0, 1'b1);
    checks++;
    if (grant !== 3'b100) $display("[TB] FAIL pre_reset_grant: got %b, need 100", grant);
    else passed++;
    tick(3'b100, 1'b0, 1'b0);
    checks++;
    if ({grant, busy, prio, timeout} !== {3'b000, 1'b0, 3'b001, 1'b0})
      $display("[TB] FAIL mid_busy_reset: got %b, need 00000010", {grant, busy, prio, timeout});
    else passed++;
    tick(3'b100, 1'b0, 1'b1);
    checks++;
    if (grant !== 3'b100) $display("[TB] FAIL regrant_after_reset: got %b, need 100", grant);
    else passed++;
    tick(3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_req_drop();
    tick(3'b011, 1'b0, 1'b1);
    checks++;
    if (grant !== 3'b001) $display("[TB] FAIL drop_setup: got %b, need 001", grant);
    else passed++;
    tick(3'b011, 1'b0, 1'b1);
    tick(3'b010, 1'b0, 1'b1);
    checks++;
    if ({grant, timeout} !== {3'b000, 1'b0}) $display("[TB] FAIL drop_gap: got %b, need 0000", {grant, timeout});
    else passed++;
    tick(3'b010, 1'b0, 1'b1);
    tick(3'b010, 1'b0, 1'b1);
    checks++;
    if (grant !== 3'b010) $display("[TB] FAIL drop_next_owner: got %b, need 010", grant);
    else passed++;
  endtask

  task automatic test_random();
    logic [2:0] r;
    logic d;
    logic rs;
    r = 3'b000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
      d  = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 99) != 0);
      tick(r, d, rs);
      checks++;
      if ({grant, busy, prio, timeout} !== model_out())
        $display("[TB] FAIL random cycle %0d: got %b, need %b", i, {grant, busy, prio, timeout}, model_out());
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_timeout();
    test_done_at_limit();
    test_reset_mid_busy();
    test_req_drop();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
